// File: rtl/alu_sequencer.sv
// Multi-cycle single-issue controller: fetches from imem, sequences the
// ALU, writes results back to the register file and tracks the PC.
module alu_sequencer #(
    parameter int WORD_W  = 32,
    parameter int OP_W    = 5,
    parameter int IMEM_AW = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_valid,
    input  logic [31:0]        imem_rdata,
    output logic [4:0]         rf_ra_addr,
    output logic [4:0]         rf_rb_addr,
    input  logic [WORD_W-1:0]  rf_ra_data,
    input  logic [WORD_W-1:0]  rf_rb_data,
    output logic               rf_we,
    output logic [4:0]         rf_wa,
    output logic [WORD_W-1:0]  rf_wd,
    output logic [OP_W-1:0]    operator,
    output logic [WORD_W-1:0]  arg_a,
    output logic [WORD_W-1:0]  arg_b,
    output logic [WORD_W-1:0]  currpc,
    input  logic [WORD_W-1:0]  nxtpc,
    input  logic [WORD_W-1:0]  result,
    output logic               busy,
    output logic               halted,
    output logic [WORD_W-1:0]  retired
);

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [WORD_W-1:0]  res_q, res_d;
    logic [WORD_W-1:0]  npc_q, npc_d;
    logic [WORD_W-1:0]  retired_q, retired_d;
    logic [WORD_W-1:0]  imm_sext;
    logic [4:0]         rd;

    assign rd         = ir_q[26:22];
    assign imm_sext   = {{(WORD_W-11){ir_q[10]}}, ir_q[10:0]};
    assign rf_ra_addr = ir_q[21:17];
    assign rf_rb_addr = ir_q[16:12];
    assign imem_addr  = pc_q[IMEM_AW-1:0];
    assign retired    = retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            res_q     <= '0;
            npc_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            res_q     <= res_d;
            npc_q     <= npc_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        res_d     = res_q;
        npc_d     = npc_q;
        retired_d = retired_q;
        imem_req  = 1'b0;
        rf_we     = 1'b0;
        rf_wa     = '0;
        rf_wd     = '0;
        busy      = 1'b0;
        halted    = 1'b0;
        operator  = '0;
        arg_a     = '0;
        arg_b     = '0;
        currpc    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = (imem_rdata == HALT_WORD) ? S_HALT : S_EXEC;
                end
            end
            S_EXEC: begin
                busy    = 1'b1;
                res_d   = result;
                npc_d   = nxtpc;
                state_d = S_WB;
            end
            S_WB: begin
                busy      = 1'b1;
                rf_we     = (rd != 5'd0);
                rf_wa     = rd;
                rf_wd     = res_q;
                pc_d      = npc_q;
                retired_d = retired_q + 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // ALU inputs follow the latched instruction only while running
        if (busy) begin
            operator = OP_W'(ir_q[31:27]);
            arg_a    = rf_ra_data;
            arg_b    = ir_q[11] ? imm_sext : rf_rb_data;
            currpc   = pc_q;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench: behavioural imem, register file and ALU around the
// sequencer, with hand-computed expectations.
module tb_alu_sequencer;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_JMP = 5'd2;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [4:0]  rf_ra_addr, rf_rb_addr;
    logic [31:0] rf_ra_data, rf_rb_data;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [4:0]  operator;
    logic [31:0] arg_a, arg_b, currpc, nxtpc, result;
    logic        busy, halted;
    logic [31:0] retired;

    logic [31:0] mem [1024];
    logic [31:0] rf [32];
    int          lat;
    int          cnt;
    int          we_cnt;
    logic [9:0]  last_fetch;
    int          n_chk;
    int          n_pass;

    alu_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_valid(imem_valid),
        .imem_rdata(imem_rdata),
        .rf_ra_addr(rf_ra_addr),
        .rf_rb_addr(rf_rb_addr),
        .rf_ra_data(rf_ra_data),
        .rf_rb_data(rf_rb_data),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .operator  (operator),
        .arg_a     (arg_a),
        .arg_b     (arg_b),
        .currpc    (currpc),
        .nxtpc     (nxtpc),
        .result    (result),
        .busy      (busy),
        .halted    (halted),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];
    assign imem_valid = imem_req && (cnt == lat);
    assign rf_ra_data = rf[rf_ra_addr];
    assign rf_rb_data = rf[rf_rb_addr];

    // Conditional jump: link/target when arg_a != 0, else fall through.
    always_comb begin
        result = 32'd0;
        nxtpc  = currpc + 32'd1;
        case (operator)
            OP_ADD: result = arg_a + arg_b;
            OP_SUB: result = arg_a - arg_b;
            OP_JMP: begin
                if (arg_a != 32'd0) begin
                    result = currpc;
                    nxtpc  = arg_b;
                end
            end
            default: result = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (!imem_req || imem_valid) cnt <= 0;
        else                         cnt <= cnt + 1;
        if (rst_n && rf_we) begin
            rf[rf_wa] = rf_wd;
            we_cnt    = we_cnt + 1;
        end
        if (imem_req && imem_valid) last_fetch = imem_addr;
    end

    function automatic logic [31:0] ins(input logic [4:0] op,
                                        input logic [4:0] rd,
                                        input logic [4:0] ra,
                                        input logic [4:0] rb,
                                        input logic ui,
                                        input logic [10:0] imm);
        return {op, rd, ra, rb, ui, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt();
        int k;
        k = 0;
        while (!halted && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        int wc;
        n_chk  = 0;
        n_pass = 0;
        we_cnt = 0;
        cnt    = 0;
        lat    = 1;
        last_fetch = '0;
        start  = 1'b0;
        rst_n  = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = HALTW;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;

        tick(2);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        rst_n = 1'b1;
        tick(1);

        // ADD r3,r1,r2 with 1-cycle memory
        mem[0] = ins(OP_ADD, 5'd3, 5'd1, 5'd2, 1'b0, 11'd0);
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        pulse_start();
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr", {22'd0, imem_addr}, 32'd0);
        tick(2);
        chk("t1_op", {27'd0, operator}, {27'd0, OP_ADD});
        chk("t1_arga", arg_a, 32'd5);
        chk("t1_argb", arg_b, 32'd7);
        chk("t1_currpc", currpc, 32'd0);
        tick(1);
        chk("t1_we", {31'd0, rf_we}, 32'd1);
        chk("t1_wa", {27'd0, rf_wa}, 32'd3);
        chk("t1_wd", rf_wd, 32'd12);
        tick(1);
        chk("t1_we_drop", {31'd0, rf_we}, 32'd0);
        chk("t1_retired", retired, 32'd1);
        chk("t1_pc", currpc, 32'd1);
        chk("t1_addr1", {22'd0, imem_addr}, 32'd1);
        wait_halt();
        chk("t1_halt_busy", {31'd0, busy}, 32'd0);
        chk("t1_wecnt", we_cnt, 32'd1);
        chk("t1_r3", rf[3], 32'd12);

        // SUB r4,r1,#-3
        mem[0] = ins(OP_SUB, 5'd4, 5'd1, 5'd0, 1'b1, 11'h7FD);
        rf[1] = 32'd10;
        pulse_start();
        tick(2);
        chk("t2_op", {27'd0, operator}, {27'd0, OP_SUB});
        chk("t2_argb", arg_b, 32'hFFFF_FFFD);
        tick(1);
        chk("t2_wa", {27'd0, rf_wa}, 32'd4);
        chk("t2_wd", rf_wd, 32'd13);
        wait_halt();
        chk("t2_retired", retired, 32'd2);

        // JMP r5,r1,#20 at pc 6, taken then not taken
        for (int i = 0; i < 6; i++) mem[i] = 32'd0;
        mem[6] = ins(OP_JMP, 5'd5, 5'd1, 5'd0, 1'b1, 11'd20);
        rf[1] = 32'd1;
        wc = we_cnt;
        pulse_start();
        wait_halt();
        chk("t3_r5_taken", rf[5], 32'd6);
        chk("t3_fetch_taken", {22'd0, last_fetch}, 32'd20);
        chk("t3_wecnt", we_cnt - wc, 32'd1);
        chk("t3_retired", retired, 32'd9);
        rf[1] = 32'd0;
        rf[5] = 32'd99;
        pulse_start();
        wait_halt();
        chk("t3_r5_nt", rf[5], 32'd0);
        chk("t3_fetch_nt", {22'd0, last_fetch}, 32'd7);
        chk("t3_retired_nt", retired, 32'd16);

        // rd = 0: no write, still retires
        mem[0] = ins(OP_ADD, 5'd0, 5'd1, 5'd2, 1'b0, 11'd0);
        mem[1] = HALTW;
        rf[1] = 32'd5;
        wc = we_cnt;
        pulse_start();
        tick(3);
        chk("t4_we", {31'd0, rf_we}, 32'd0);
        wait_halt();
        chk("t4_wecnt", we_cnt - wc, 32'd0);
        chk("t4_r0", rf[0], 32'd0);
        chk("t4_retired", retired, 32'd17);
        chk("t4_fetch", {22'd0, last_fetch}, 32'd1);

        // 3-cycle memory wait
        mem[0] = ins(OP_ADD, 5'd6, 5'd1, 5'd2, 1'b0, 11'd0);
        mem[1] = ins(OP_ADD, 5'd7, 5'd1, 5'd2, 1'b0, 11'd0);
        mem[2] = HALTW;
        lat = 3;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk("t5_req_hold", {31'd0, imem_req}, 32'd1);
            chk("t5_addr_hold", {22'd0, imem_addr}, 32'd0);
            tick(1);
        end
        chk("t5_req_drop", {31'd0, imem_req}, 32'd0);
        tick(1);
        chk("t5_we0", {31'd0, rf_we}, 32'd1);
        chk("t5_wa0", {27'd0, rf_wa}, 32'd6);
        chk("t5_wd0", rf_wd, 32'd12);
        tick(6);
        chk("t5_we1", {31'd0, rf_we}, 32'd1);
        chk("t5_wa1", {27'd0, rf_wa}, 32'd7);
        wc = we_cnt;
        wait_halt();
        chk("t5_halt_busy", {31'd0, busy}, 32'd0);
        chk("t5_halt_nowe", we_cnt - wc, 32'd1);
        chk("t5_retired", retired, 32'd19);
        lat = 1;
        pulse_start();
        chk("t5_restart_req", {31'd0, imem_req}, 32'd1);
        chk("t5_restart_addr", {22'd0, imem_addr}, 32'd0);

        // Async reset in the middle of a write-back
        tick(3);
        chk("t6_we_pre", {31'd0, rf_we}, 32'd1);
        wc = we_cnt;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_we_async", {31'd0, rf_we}, 32'd0);
        chk("t6_busy_async", {31'd0, busy}, 32'd0);
        chk("t6_retired_async", retired, 32'd0);
        tick(2);
        rst_n = 1'b1;
        chk("t6_no_write", we_cnt - wc, 32'd0);
        tick(5);
        chk("t6_idle_busy", {31'd0, busy}, 32'd0);
        chk("t6_idle_halted", {31'd0, halted}, 32'd0);
        chk("t6_idle_req", {31'd0, imem_req}, 32'd0);
        chk("t6_idle_currpc", currpc, 32'd0);
        chk("t6_idle_arga", arg_a, 32'd0);
        chk("t6_idle_retired", retired, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control-side counterpart of the combinational ALU: owns the PC and fetches instructions from instruction memory.
- Reads operands from the register file and drives the ALU's operator, arg_a, arg_b and currpc inputs.
- Consumes the ALU's result and nxtpc outputs: writes result back to the register file and loads nxtpc into the PC.
- Sits between instruction memory, register file and ALU as the single-issue, multi-cycle core controller.

Parameters:
- WORD_W, 32, datapath/PC width; must equal the ALU word width.
- OP_W, 5, operator field width; must equal the ALU operator width.
- IMEM_AW, 10, instruction memory address width; imem_addr = pc[IMEM_AW-1:0].

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins execution from PC 0 when in IDLE or HALT.
- imem_req  out  1  fetch request; held high until imem_valid.
- imem_addr  out  IMEM_AW  fetch address.
- imem_valid  in  1  instruction data valid; the earliest response is the cycle after req.
- imem_rdata  in  32  instruction word.
- rf_ra_addr  out  5  register read address A (ir[21:17]).
- rf_rb_addr  out  5  register read address B (ir[16:12]).
- rf_ra_data  in  WORD_W  combinational read data A.
- rf_rb_data  in  WORD_W  combinational read data B.
- rf_we  out  1  register write enable; one-cycle pulse.
- rf_wa  out  5  write address (ir[26:22]).
- rf_wd  out  WORD_W  write data.
- operator  out  OP_W  to ALU.
- arg_a  out  WORD_W  to ALU.
- arg_b  out  WORD_W  to ALU.
- currpc  out  WORD_W  to ALU; equals pc.
- nxtpc  in  WORD_W  from ALU.
- result  in  WORD_W  from ALU.
- busy  out  1  high in FETCH/EXEC/WB.
- halted  out  1  high in HALT.
- retired  out  WORD_W  count of written-back instructions; wraps at 2^WORD_W.

Behaviour:
- Instruction format (32 bits):
  - [31:27] op
  - [26:22] rd
  - [21:17] ra
  - [16:12] rb
  - [11] use_imm
  - [10:0] imm, sign-extended to WORD_W
  - Word 32'hFFFF_FFFF is HALT.
- ALU drive:
  - operator = ir[31:27]
  - arg_a = rf_ra_data
  - arg_b = use_imm ? sext(imm) : rf_rb_data
  - currpc = pc
  - All four are held stable throughout EXEC and WB; they read 0 in IDLE and HALT.
- Opcode encodings are the global opcode definitions shared with the ALU. JMP needs no special handling here: the ALU returns the link value in result and the target in nxtpc.
- States:
  - IDLE: on start, pc<=0, go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc[IMEM_AW-1:0]. On imem_valid, ir<=imem_rdata. If rdata is HALT, go to HALT with pc unchanged; otherwise go to EXEC.
  - EXEC: one cycle; ALU settles; res_q<=result, npc_q<=nxtpc.
  - WB: rf_we=1 unless rd==0 (r0 is read-only, write suppressed). rf_wa=rd, rf_wd=res_q. pc<=npc_q, retired<=retired+1 (also counts rd==0 instructions). Go to FETCH.
  - HALT: halted=1; start goes to FETCH with pc<=0. retired is not cleared.
- Latency: with a next-cycle imem_valid, 4 cycles per instruction (FETCH 2, EXEC 1, WB 1). Each extra memory wait cycle adds 1.
- PC arithmetic is mod 2^WORD_W; imem_addr uses the low IMEM_AW bits, so fetches wrap through memory.
- start is ignored while busy.
- imem_valid outside FETCH is ignored. imem_req drops in the cycle after valid is sampled.
- rf_we is never high outside WB.
- Reset (at any time, including mid-instruction): state IDLE; pc, ir, res_q, npc_q, retired = 0. All outputs = 0, including imem_req, rf_we, busy and halted. No partial write-back completes.

Test Plan:
- Reset then start; imem returns ADD r3,r1,r2 (r1=5, r2=7) with 1-cycle latency -> operator=ADD, arg_a=5, arg_b=7, currpc=0 during EXEC. Exactly one rf_we pulse with rf_wa=3, rf_wd=12, four cycles after start. pc becomes 1; retired=1.
- Immediate path: SUB r4,r1,imm=-3 (use_imm=1, imm=11'h7FD), r1=10 -> arg_b=32'hFFFF_FFFD; rf_wd=13 to r4.
- JMP r5,r1,imm=20 at pc=6, r1=1 -> r5<=6, next fetch addr=20. Same instruction with r1=0 -> r5<=0, next fetch addr=7.
- Write to rd=0 (ADD r0,r1,r2) -> rf_we stays 0; pc advances; retired increments.
- Memory wait: imem_valid delayed 3 cycles -> imem_req held high and addr stable throughout; instruction period becomes 6 cycles. Fetching 32'hFFFF_FFFF -> halted=1, busy=0, no rf_we. A following start restarts at addr 0.
- Assert rst_n=0 during WB of a pending write -> rf_we drops immediately (async). After release: state IDLE, all outputs 0, retired=0, start-pulse-less idle holds.
